alu: RTL and testbench

//  Registered 16-bit Hack-style ALU for the CPU datapath: conditions two operands
//  (zero/negate), computes x+y or x&y, optionally negates the result, and flags

---
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered Hack-style ALU: operand conditioning, ripple-carry add or bitwise AND,
// optional result negation, with zero/negative flags held alongside the result.

module alu_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] x1, x2, y1, y2;
  logic [WIDTH-1:0] sum, r, o;
  logic [WIDTH-1:0] carry;
  logic             cout_unused;

  always_comb begin
    x1 = zx ? '0 : x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? '0 : y;
    y2 = ny ? ~y1 : y1;
  end

  assign carry[0] = 1'b0;

  // Final carry-out is dropped: the sum wraps modulo 2^WIDTH.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    if (i < WIDTH - 1) begin : g_mid
      alu_fa u_fa (
        .a    (x2[i]),
        .b    (y2[i]),
        .cin  (carry[i]),
        .sum  (sum[i]),
        .cout (carry[i+1])
      );
    end else begin : g_last
      alu_fa u_fa (
        .a    (x2[i]),
        .b    (y2[i]),
        .cin  (carry[i]),
        .sum  (sum[i]),
        .cout (cout_unused)
      );
    end
  end

  always_comb begin
    r = f ? sum : (x2 & y2);
    o = no ? ~r : r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= o;
        zr  <= (o == '0);
        ng  <= o[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed Hack codes, streaming/hold behaviour,
// randomized traffic against an arithmetic model, and an exhaustive 2-bit adder sweep.

module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic        out_valid;
  logic [15:0] out;
  logic        zr, ng;

  logic        s_in_valid;
  logic [1:0]  s_x, s_y;
  logic        s_out_valid;
  logic [1:0]  s_out;
  logic        s_zr, s_ng;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out_valid(out_valid), .out(out), .zr(zr), .ng(ng)
  );

  alu #(.WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .x(s_x), .y(s_y),
    .zx(1'b0), .nx(1'b0), .zy(1'b0), .ny(1'b0), .f(1'b1), .no(1'b0),
    .out_valid(s_out_valid), .out(s_out), .zr(s_zr), .ng(s_ng)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ctrl = {zx,nx,zy,ny,f,no}; negation as 65535 - v, addition mod 65536.
  function automatic int unsigned ref_alu(input logic [5:0] ctrl, input int unsigned a,
                                          input int unsigned b);
    int unsigned xa, yb, r;
    xa = ctrl[5] ? 0 : a;
    if (ctrl[4]) xa = 65535 - xa;
    yb = ctrl[3] ? 0 : b;
    if (ctrl[2]) yb = 65535 - yb;
    r = ctrl[1] ? (xa + yb) % 65536 : (xa & yb);
    if (ctrl[0]) r = 65535 - r;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [5:0] ctrl, input logic [15:0] a,
                       input logic [15:0] b);
    in_valid = v;
    {zx, nx, zy, ny, f, no} = ctrl;
    x = a;
    y = b;
  endtask

  // Issue one op at a falling edge and check it after the following rising edge.
  task automatic op_check(input string tag, input logic [5:0] ctrl, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
    drive(1'b1, ctrl, a, b);
    @(negedge clk);
    check({tag, ".out"}, 32'(out), 32'(exp));
    check({tag, ".zr"}, 32'(zr), 32'(exp == 16'h0));
    check({tag, ".ng"}, 32'(ng), 32'(exp[15]));
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] ra, rb;
    logic [5:0]  rc;
    logic        rv;
    int unsigned e;

    rst_n = 1'b0;
    s_in_valid = 1'b1;
    s_x = 2'd3;
    s_y = 2'd3;
    drive(1'b1, 6'b000010, 16'h7095, 16'h2795);
    @(negedge clk);
    @(negedge clk);
    check("rst.out", 32'(out), 32'd0);
    check("rst.zr", 32'(zr), 32'd0);
    check("rst.ng", 32'(ng), 32'd0);
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.small_vld", 32'(s_out_valid), 32'd0);

    rst_n = 1'b1;
    op_check("add", 6'b000010, 16'h7095, 16'h2795, 16'h982A);
    op_check("wrap", 6'b000010, 16'hFFFF, 16'h0001, 16'h0000);
    op_check("and", 6'b000000, 16'h7095, 16'h2795, 16'h2095);
    op_check("or", 6'b010101, 16'h7095, 16'h2795, 16'h7795);
    op_check("xmy", 6'b010011, 16'h7095, 16'h2795, 16'h4900);
    op_check("ymx", 6'b000111, 16'h7095, 16'h2795, 16'hB700);
    op_check("zero", 6'b101010, 16'h7095, 16'h2795, 16'h0000);
    op_check("one", 6'b111111, 16'h7095, 16'h2795, 16'h0001);
    op_check("neg1", 6'b111010, 16'h7095, 16'h2795, 16'hFFFF);
    op_check("passx", 6'b001100, 16'h7095, 16'h2795, 16'h7095);
    op_check("passy", 6'b110000, 16'h7095, 16'h2795, 16'h2795);
    op_check("notx", 6'b001101, 16'h7095, 16'h2795, 16'h8F6A);

    // Three back-to-back ops then an idle cycle: result must hold, valid drops.
    op_check("b2b0", 6'b000010, 16'h0001, 16'h0002, 16'h0003);
    op_check("b2b1", 6'b000010, 16'h0010, 16'h0020, 16'h0030);
    op_check("b2b2", 6'b000000, 16'hF0F0, 16'h8F00, 16'h8000);
    drive(1'b0, 6'b101010, 16'h1234, 16'h5678);
    @(negedge clk);
    check("idle.vld", 32'(out_valid), 32'd0);
    check("idle.out", 32'(out), 32'h8000);
    check("idle.ng", 32'(ng), 32'd1);
    check("idle.zr", 32'(zr), 32'd0);

    held = 16'h8000;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = 6'($urandom);
      ra = 16'($urandom);
      rb = (i % 7 == 0) ? 16'(16'h0 - ra) : 16'($urandom);
      drive(rv, rc, ra, rb);
      @(negedge clk);
      if (rv) held = 16'(ref_alu(rc, 32'(ra), 32'(rb)));
      check("rnd.vld", 32'(out_valid), 32'(rv));
      check("rnd.out", 32'(out), 32'(held));
      check("rnd.zr", 32'(zr), 32'(held == 16'h0));
      check("rnd.ng", 32'(ng), 32'(held[15]));
    end

    // Every operand pair on the 2-bit instance drives each full-adder row.
    in_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        s_in_valid = 1'b1;
        s_x = 2'(a);
        s_y = 2'(b);
        @(negedge clk);
        e = (a + b) % 4;
        check("fa2.out", 32'(s_out), e);
        check("fa2.zr", 32'(s_zr), 32'(e == 0));
        check("fa2.ng", 32'(s_ng), 32'(e >= 2));
        check("fa2.vld", 32'(s_out_valid), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
